// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC select, stall, trap redirect,
// misaligned-target detection and a small circular return-address stack.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             trap,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] imm_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] pc_prev,
    output logic             misaligned,
    output logic [WIDTH-1:0] bad_addr,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] bad_next;
    logic             mis_next;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]    sp;
    logic [AW-1:0]    top_idx;
    logic [CW-1:0]    count;
    logic             ras_en;
    logic             do_push;
    logic             do_pop;
    logic             has_entry;

    assign pc_plus4 = pc + WIDTH'(4);

    always_comb begin
        target = pc_plus4;
        unique case (pc_src)
            2'b01:   target = pc + imm_op;
            2'b10:   target = alu_result & ~WIDTH'(1);
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        pc_next  = pc;
        mis_next = 1'b0;
        bad_next = bad_addr;
        if (trap) begin
            pc_next = TRAP_VECTOR;
        end else if (!stall) begin
            if (target[1:0] != 2'b00) begin
                pc_next  = TRAP_VECTOR;
                mis_next = 1'b1;
                bad_next = target;
            end else begin
                pc_next = target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_VECTOR;
            pc_prev    <= RESET_VECTOR;
            misaligned <= 1'b0;
            bad_addr   <= '0;
        end else begin
            pc         <= pc_next;
            misaligned <= mis_next;
            bad_addr   <= bad_next;
            if (pc_next != pc) pc_prev <= pc;
        end
    end

    // sp is the next free slot; the top entry sits just below it
    assign top_idx   = sp - AW'(1);
    assign has_entry = (count != '0);
    assign ras_en    = !stall && !trap;
    assign do_push   = ras_en && ras_push;
    assign do_pop    = ras_en && ras_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp    <= '0;
            count <= '0;
        end else if (do_push && do_pop && has_entry) begin
            sp    <= sp;
            count <= count;
        end else if (do_push) begin
            sp <= sp + AW'(1);
            if (count != FULL_CNT) count <= count + CW'(1);
        end else if (do_pop && has_entry) begin
            sp    <= sp - AW'(1);
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            if (do_pop && has_entry) ras_mem[top_idx] <= pc_plus4;
            else                     ras_mem[sp]      <= pc_plus4;
        end
    end

    assign ras_empty = !has_entry;
    assign ras_full  = (count == FULL_CNT);
    assign ras_top   = has_entry ? ras_mem[top_idx] : '0;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised next-generation program counter for the fetch stage. Extends plain next-PC selection with:
- fetch stall
- trap redirect
- instruction-address-misalignment detection
- a small return-address stack (RAS) for call/return target prediction

Sits between the control/branch logic and instruction memory. Drives the fetch address every cycle.

Parameters:
WIDTH, 32, address/data width of PC and all target operands
RESET_VECTOR, 32'h0000_0000, PC value after reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned target
RAS_DEPTH, 4, number of RAS entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
stall  input  1  hold PC (pipeline bubble/hazard)
trap  input  1  take trap: redirect to TRAP_VECTOR
pc_src  input  2  00 seq, 01 PC+imm (branch/JAL), 10 JALR, 11 reserved
imm_op  input  WIDTH  sign-extended immediate for PC-relative target
alu_result  input  WIDTH  rs1+imm for JALR target
ras_push  input  1  call: push pc_plus4
ras_pop  input  1  return: pop top entry
pc  output  WIDTH  current fetch address
pc_plus4  output  WIDTH  pc + 4, combinational
pc_prev  output  WIDTH  PC value before the last update
misaligned  output  1  one-cycle pulse: last selected target was misaligned
bad_addr  output  WIDTH  misaligned target captured with the pulse
ras_top  output  WIDTH  top RAS entry; 0 when empty
ras_empty  output  1  RAS holds no entries
ras_full  output  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset (rst=0, asynchronous, any time incl. mid-operation):
  - pc=RESET_VECTOR, pc_prev=RESET_VECTOR
  - misaligned=0, bad_addr=0
  - RAS count=0, stack pointer=0, entries need not be cleared
  - Outputs valid immediately; first update on the first rising edge after deassertion.
- Target selection (combinational, modulo 2^WIDTH, wrap-around silent):
  - 00: pc+4
  - 01: pc+imm_op
  - 10: alu_result with bit0 forced to 0
  - 11: pc+4
- Per-edge priority, highest first:
  1. trap=1: pc<=TRAP_VECTOR. Overrides stall and pc_src. misaligned<=0.
  2. stall=1: pc, pc_prev, bad_addr hold; misaligned<=0.
  3. Target bits[1:0]!=0: pc<=TRAP_VECTOR, misaligned<=1 for exactly one cycle, bad_addr<=target.
  4. Otherwise: pc<=target, misaligned<=0.
- Whenever pc changes, pc_prev<=old pc. This includes a trap or misalignment redirect.
- Single-cycle latency: the selected target appears on pc the cycle after the edge.
- RAS:
  - Circular buffer.
  - Push/pop are ignored while stall=1 or trap=1.
  - Push writes pc_plus4 of the current cycle.
  - Push only: write at the next slot; count+1.
  - Push when full: overwrite the oldest entry; count stays RAS_DEPTH; no error.
  - Pop only: count-1. Pop when empty: no change.
  - Push+pop in the same cycle: overwrite the top entry with pc_plus4; count unchanged. If empty, behaves as push only.
  - ras_top, ras_empty and ras_full are combinational from registered state.
- The RAS does not influence pc directly. The consumer selects ras_top via alu_result/pc_src.

Test Plan:
- Reset then 3 edges, pc_src=00 -> pc sequence 0x0, 0x4, 0x8, 0xC; pc_prev=0x8; pc_plus4=0x10.
- pc=0x20, pc_src=01, imm_op=0xFFFFFFF0 -> pc=0x10. Then pc=0xFFFFFFFC with pc_src=00 -> pc=0x0 (wrap).
- pc_src=10, alu_result=0x103 -> misaligned pulse 1 cycle, bad_addr=0x102, pc=0x100. Same cycle with stall=1 -> pc holds, no pulse. Same cycle with trap=1 -> pc=0x100, no pulse.
- stall=1 for 3 cycles at pc=0x40 with pc_src=01 -> pc stays 0x40, pc_prev unchanged. Trap asserted during stall -> pc=0x100, pc_prev=0x40.
- RAS_DEPTH=4: push at pc=0x0, 0x4, 0x8, 0xC, 0x10 -> ras_full=1, ras_top=0x14. Four pops -> ras_top 0x10, 0xC, 0x8 then ras_empty=1. Fifth pop -> no change.
- Push+pop together at pc=0x30 with top=0x8 -> ras_top=0x34, count unchanged. Assert rst mid-sequence -> pc=RESET_VECTOR and ras_empty=1 before the next edge.
